// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/HALTED control with sequential advance,
// conditional PC-relative and register redirects, link capture and retire count.
module pc_sequencer (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic        pcAdvance,
    input  logic        resJump,
    input  logic [3:0]  brhSel,
    input  logic [15:0] immOffset,
    input  logic [31:0] regTarget,
    input  logic        haltInstr,
    output logic [31:0] pc,
    output logic        pcValid,
    output logic        linkWe,
    output logic [31:0] linkData,
    output logic        jumpTaken,
    output logic        halted,
    output logic [31:0] instrCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    logic        take_branch;
    logic        is_reg_jump;
    logic        is_link;
    logic [31:0] imm_ext;
    logic [31:0] branch_target;
    logic [31:0] pc_next_seq;

    always_comb begin
        take_branch   = brhSel[3] & resJump;
        is_reg_jump   = (brhSel == 4'b1101);
        is_link       = (brhSel == 4'b1001);
        imm_ext       = {{16{immOffset[15]}}, immOffset};
        pc_next_seq   = pc + 32'd1;
        branch_target = is_reg_jump ? regTarget : (pc + imm_ext);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            pc         <= 32'd0;
            pcValid    <= 1'b0;
            linkWe     <= 1'b0;
            linkData   <= 32'd0;
            jumpTaken  <= 1'b0;
            halted     <= 1'b0;
            instrCount <= 32'd0;
        end else begin
            // Pulses default low; only a redirecting commit raises them.
            linkWe    <= 1'b0;
            jumpTaken <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state      <= RUN;
                        pc         <= 32'd0;
                        instrCount <= 32'd0;
                        pcValid    <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                RUN: begin
                    if (pcAdvance) begin
                        instrCount <= instrCount + 32'd1;
                        if (haltInstr) begin
                            state   <= HALTED;
                            pcValid <= 1'b0;
                            halted  <= 1'b1;
                        end else if (take_branch) begin
                            pc        <= branch_target;
                            jumpTaken <= 1'b1;
                            if (is_link) begin
                                linkWe   <= 1'b1;
                                linkData <= pc_next_seq;
                            end
                        end else begin
                            pc <= pc_next_seq;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pcValid <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reference model pushes expected
// outputs into a queue as stimulus is driven; they are popped after the edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        pcAdvance;
    logic        resJump;
    logic [3:0]  brhSel;
    logic [15:0] immOffset;
    logic [31:0] regTarget;
    logic        haltInstr;
    logic [31:0] pc;
    logic        pcValid;
    logic        linkWe;
    logic [31:0] linkData;
    logic        jumpTaken;
    logic        halted;
    logic [31:0] instrCount;

    pc_sequencer dut (
        .clk        (clk),
        .rstN       (rstN),
        .start      (start),
        .pcAdvance  (pcAdvance),
        .resJump    (resJump),
        .brhSel     (brhSel),
        .immOffset  (immOffset),
        .regTarget  (regTarget),
        .haltInstr  (haltInstr),
        .pc         (pc),
        .pcValid    (pcValid),
        .linkWe     (linkWe),
        .linkData   (linkData),
        .jumpTaken  (jumpTaken),
        .halted     (halted),
        .instrCount (instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [31:0] link;
        logic        valid;
        logic        lwe;
        logic        jt;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // reference model state: 0 idle, 1 run, 2 halted
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_link;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'd0;
        m_cnt   = 32'd0;
        m_link  = 32'd0;
    endtask

    task automatic step(input logic s, input logic a, input logic r,
                        input logic [3:0] b, input logic [15:0] imm,
                        input logic [31:0] tgt, input logic h);
        exp_t e;
        exp_t got;
        logic jt;
        logic lw;
        start     = s;
        pcAdvance = a;
        resJump   = r;
        brhSel    = b;
        immOffset = imm;
        regTarget = tgt;
        haltInstr = h;
        jt = 1'b0;
        lw = 1'b0;
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                m_pc    = 32'd0;
                m_cnt   = 32'd0;
            end
        end else if (a) begin
            m_cnt = m_cnt + 32'd1;
            if (h) begin
                m_state = 2;
            end else if (b[3] && r) begin
                jt = 1'b1;
                if (b == 4'b1001) begin
                    lw     = 1'b1;
                    m_link = m_pc + 32'd1;
                end
                if (b == 4'b1101) m_pc = tgt;
                else m_pc = m_pc + {{16{imm[15]}}, imm};
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end
        e.pc    = m_pc;
        e.cnt   = m_cnt;
        e.link  = m_link;
        e.valid = (m_state == 1);
        e.lwe   = lw;
        e.jt    = jt;
        e.hlt   = (m_state == 2);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("pc", pc, got.pc);
        check("instrCount", instrCount, got.cnt);
        check("linkData", linkData, got.link);
        check("pcValid", {31'd0, pcValid}, {31'd0, got.valid});
        check("linkWe", {31'd0, linkWe}, {31'd0, got.lwe});
        check("jumpTaken", {31'd0, jumpTaken}, {31'd0, got.jt});
        check("halted", {31'd0, halted}, {31'd0, got.hlt});
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    endtask

    task automatic adv(input logic r, input logic [3:0] b,
                       input logic [15:0] imm, input logic [31:0] tgt,
                       input logic h);
        step(1'b0, 1'b1, r, b, imm, tgt, h);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_valid"}, {31'd0, pcValid}, 32'd0);
        check({tag, "_linkWe"}, {31'd0, linkWe}, 32'd0);
        check({tag, "_linkData"}, linkData, 32'd0);
        check({tag, "_jump"}, {31'd0, jumpTaken}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_count"}, instrCount, 32'd0);
    endtask

    logic [31:0] cnt_at7;

    initial begin
        rstN      = 1'b0;
        start     = 1'b0;
        pcAdvance = 1'b0;
        resJump   = 1'b0;
        brhSel    = 4'h0;
        immOffset = 16'h0;
        regTarget = 32'h0;
        haltInstr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_values("rst");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // pcAdvance in IDLE has no effect
        step(1'b0, 1'b1, 1'b1, 4'b1101, 16'h0, 32'h55, 1'b0);
        idle_step();
        step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);

        // three sequential retires, back to back
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        check("seq3_pc", pc, 32'd3);
        check("seq3_cnt", instrCount, 32'd3);

        // start ignored while running; no advance holds state
        step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        check("run_start_pc", pc, 32'd3);

        // negative PC-relative branch from 10
        adv(1'b1, 4'b1101, 16'h0, 32'd10, 1'b0);
        adv(1'b1, 4'b1011, 16'hFFFC, 32'h0, 1'b0);
        check("neg_br_pc", pc, 32'd6);
        check("neg_br_jt", {31'd0, jumpTaken}, 32'd1);
        check("neg_br_lw", {31'd0, linkWe}, 32'd0);
        idle_step();
        check("jt_one_cycle", {31'd0, jumpTaken}, 32'd0);

        // linking branch from 20
        adv(1'b1, 4'b1101, 16'h0, 32'd20, 1'b0);
        adv(1'b1, 4'b1001, 16'd5, 32'h0, 1'b0);
        check("link_pc", pc, 32'd25);
        check("link_data", linkData, 32'd21);
        check("link_we", {31'd0, linkWe}, 32'd1);
        idle_step();

        // non-branch class with resJump is a plain advance
        adv(1'b1, 4'b0110, 16'h0040, 32'h0, 1'b0);
        check("nonbr_pc", pc, 32'd26);

        // register jump from 7, then HALT with resJump high
        adv(1'b1, 4'b1101, 16'h0, 32'd7, 1'b0);
        cnt_at7 = instrCount;
        adv(1'b1, 4'b1101, 16'h0, 32'h100, 1'b0);
        adv(1'b1, 4'b1101, 16'h0, 32'h200, 1'b1);
        check("halt_pc", pc, 32'h100);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_cnt", instrCount - cnt_at7, 32'd2);

        // HALTED ignores pcAdvance, start restarts
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);

        // wrap through zero both ways
        adv(1'b1, 4'b1101, 16'h0, 32'hFFFF_FFFF, 1'b0);
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        check("wrap_pc", pc, 32'd0);
        adv(1'b1, 4'b0000, 16'h0, 32'h0, 1'b0);
        check("nb_pc", pc, 32'd1);
        adv(1'b1, 4'b1010, 16'hFFFE, 32'h0, 1'b0);
        check("negwrap_pc", pc, 32'hFFFF_FFFF);

        // async reset between edges with an advance pending
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        start     = 1'b0;
        pcAdvance = 1'b1;
        brhSel    = 4'b1001;
        resJump   = 1'b1;
        #3;
        rstN = 1'b0;
        #1;
        reset_values("async");
        @(posedge clk);
        #1;
        reset_values("held");
        model_reset();
        #2;
        rstN = 1'b1;
        adv(1'b1, 4'b1001, 16'd3, 32'h0, 1'b0);
        idle_step();
        idle_step();
        step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        adv(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        check("post_rst_pc", pc, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
